path_result_streamer: RTL and testbench
=======================================

PATH_RESULT_STREAMER -- requirements
Module: path_result_streamer

Interface
REQ-001 Parameter ADDR_W, default 13, output-memory address width.
REQ-002 Parameter DATA_W, default 128, output-memory word width.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 finish  in  1  level from the Bellman-Ford controller; high means the output memory holds a complete result set.
REQ-006 rd_addr  out  ADDR_W  output-memory read address.
REQ-007 rd_en  out  1  output-memory read strobe; data returns exactly 1 cycle later.
REQ-008 rd_data  in  DATA_W  output-memory read data.
REQ-009 out_valid  out  1  stream word valid.
REQ-010 out_ready  in  1  downstream accepts the word when out_valid and out_ready are both high.
REQ-011 out_data  out  16  {tag[7:0], value[7:0]}.
REQ-012 path_count  out  8  number of end-of-path records streamed since the last start.
REQ-013 busy  out  1  high outside IDLE/DONE/ERR.
REQ-014 done  out  1  one-cycle pulse on entering DONE.
REQ-015 error  out  1  sticky high in ERR until the next start or reset.

Function
REQ-016 Word format: tag = rd_data[127:120], value = rd_data[7:0]; tags 0x01 dest, 0x02 weight, 0x03 prev node, 0x0E end-of-path, 0x0F end-of-all; every other tag is illegal.
REQ-017 Start = rising edge of finish, detected against a registered copy of finish; start is acted on only in IDLE, DONE or ERR, and is ignored while busy.
REQ-018 States: IDLE, ISSUE, WAIT, SEND, DONE, ERR.
REQ-019 IDLE/DONE/ERR -> ISSUE on start; start clears rd_addr to 0, path_count to 0 and error to 0.
REQ-020 ISSUE: rd_en=1 for exactly one cycle, then -> WAIT.
REQ-021 WAIT: capture rd_data into a holding register.
  - illegal tag -> ERR
  - otherwise -> SEND
REQ-022 SEND: out_valid=1 and out_data taken from the holding register; out_data stays stable while out_valid is high and out_ready is low.
REQ-023 SEND on handshake:
  - tag 0x0F -> DONE
  - else, rd_addr == 2^ADDR_W-1 -> ERR (no wrap)
  - else rd_addr+1 -> ISSUE
REQ-024 The end-of-all word itself is streamed before DONE is entered.
REQ-025 path_count increments on the handshake of each 0x0E word, saturating at 255.
REQ-026 Throughput: at most 1 word per 3 cycles (ISSUE, WAIT, SEND); minimum start-to-first-out_valid latency is 3 cycles.
REQ-027 ERR: out_valid=0, error=1, no reads; remain in ERR until the next start.
REQ-028 A falling edge of finish mid-stream does not abort; the stream continues to the end-of-all word.
REQ-029 rd_en is never asserted outside ISSUE.
REQ-030 out_valid is never asserted outside SEND.

Reset
REQ-031 While reset is low:
  - state = IDLE
  - rd_addr=0, rd_en=0
  - out_valid=0, out_data=0
  - path_count=0, busy=0, done=0, error=0
  - finish edge register=0
REQ-032 Reset mid-stream aborts immediately; after release, a new finish rising edge is required before any read occurs, and finish held high through reset does not cause a start.

Verification
REQ-033 Memory 0:{01,05},1:{02,0x0A},2:{03,02},3:{0E,00},4:{0F,00}; finish 0->1; out_ready=1 -> words 0105,020A,0302,0E00,0F00 on consecutive 3-cycle slots, done pulse, path_count=1.
REQ-034 Same memory, out_ready low 5 cycles at word 2 -> 0302 held stable for the stall, no reads issued during the stall, same final sequence.
REQ-035 Word 1 tag 0x07 -> 0105 streamed, then ERR, error=1, out_valid=0; a new finish edge restarts from address 0 and clears error.
REQ-036 Memory filled with 0x03 tags to the top address -> ERR after the last address; rd_addr does not wrap to 0.
REQ-037 finish pulsed again while busy -> ignored; reset asserted at word 2 -> all outputs take reset values in the same cycle.

Source files
------------

// File: rtl/path_result_streamer.sv
// rtl/path_result_streamer.sv - streams tagged Bellman-Ford result words from output memory
module path_result_streamer #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 128
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              finish,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_en,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [15:0]       out_data,
   output logic [7:0]        path_count,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam logic [7:0] TAG_DEST   = 8'h01;
   localparam logic [7:0] TAG_WEIGHT = 8'h02;
   localparam logic [7:0] TAG_PREV   = 8'h03;
   localparam logic [7:0] TAG_EOP    = 8'h0E;
   localparam logic [7:0] TAG_EOA    = 8'h0F;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_SEND,
      S_DONE,
      S_ERR
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic        finish_q;
   logic        armed_q;
   logic        start;
   logic        start_ok;
   logic [7:0]  hold_tag;
   logic [7:0]  hold_val;
   logic [7:0]  wait_tag;
   logic        tag_legal;
   logic        handshake;
   logic        rd_data_unused;

   // Only the tag byte and the value byte of each memory word carry information.
   assign rd_data_unused = ^rd_data;

   // armed_q keeps a finish level held high across reset from looking like a fresh edge:
   // finish must be seen low at least once after reset before a rising edge counts.
   assign start    = finish && !finish_q && armed_q;
   assign start_ok = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);

   assign wait_tag  = rd_data[127:120];
   assign tag_legal = (wait_tag == TAG_DEST) || (wait_tag == TAG_WEIGHT) ||
                      (wait_tag == TAG_PREV) || (wait_tag == TAG_EOP) ||
                      (wait_tag == TAG_EOA);

   assign handshake = (state_q == S_SEND) && out_ready;

   assign busy     = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_SEND);
   assign error    = (state_q == S_ERR);
   assign out_data = out_valid ? {hold_tag, hold_val} : 16'h0000;

   // Finish edge detector and post-reset arming.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         finish_q <= 1'b0;
         armed_q  <= 1'b0;
      end else begin
         finish_q <= finish;
         armed_q  <= armed_q || !finish;
      end
   end

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and strobe decode; one memory word per ISSUE/WAIT/SEND round.
   always_comb begin
      state_d   = state_q;
      rd_en     = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            rd_en   = 1'b1;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            state_d = tag_legal ? S_SEND : S_ERR;
         end
         S_SEND: begin
            out_valid = 1'b1;
            if (out_ready) begin
               if (hold_tag == TAG_EOA) begin
                  state_d = S_DONE;
               end else if (rd_addr == {ADDR_W{1'b1}}) begin
                  state_d = S_ERR;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Holding register for the word returned during WAIT.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hold_tag <= 8'h00;
         hold_val <= 8'h00;
      end else if (state_q == S_WAIT) begin
         hold_tag <= rd_data[127:120];
         hold_val <= rd_data[7:0];
      end
   end

   // Read address advances after each accepted word; it never wraps past the top.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_addr <= '0;
      end else if (start && start_ok) begin
         rd_addr <= '0;
      end else if (handshake && (hold_tag != TAG_EOA) && (rd_addr != {ADDR_W{1'b1}})) begin
         rd_addr <= rd_addr + 1'b1;
      end
   end

   // Count accepted end-of-path records, saturating.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         path_count <= 8'h00;
      end else if (start && start_ok) begin
         path_count <= 8'h00;
      end else if (handshake && (hold_tag == TAG_EOP) && (path_count != 8'hFF)) begin
         path_count <= path_count + 8'h01;
      end
   end

   // Single-cycle done pulse on the transition into DONE.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         done <= 1'b0;
      end else begin
         done <= (state_d == S_DONE) && (state_q != S_DONE);
      end
   end

endmodule

// File: tb/tb_path_result_streamer.sv
// tb/tb_path_result_streamer.sv - directed self-checking bench for path_result_streamer
module tb_path_result_streamer;

   logic         clock;
   logic         reset;
   logic         finish;
   logic [12:0]  rd_addr;
   logic         rd_en;
   logic [127:0] rd_data;
   logic         out_valid;
   logic         out_ready;
   logic [15:0]  out_data;
   logic [7:0]   path_count;
   logic         busy;
   logic         done;
   logic         error;

   int checks;
   int errors;

   logic [127:0] mem [0:8191];

   logic [15:0] got_data [$];
   int          got_cyc [$];
   int          rd_count;
   int          rd_while_valid;
   int          done_pulses;
   int          stall_diff;
   logic        err_c1;
   logic        rden_c1;
   logic [12:0] addr_c1;

   path_result_streamer dut (
      .clock      (clock),
      .reset      (reset),
      .finish     (finish),
      .rd_addr    (rd_addr),
      .rd_en      (rd_en),
      .rd_data    (rd_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .path_count (path_count),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always #5 clock = ~clock;

   // Synchronous output memory: data appears one cycle after the read strobe.
   always @(posedge clock) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

   function automatic logic [127:0] make_word(input logic [7:0] tag, input logic [7:0] val);
      return {tag, {14{8'h5A}}, val};
   endfunction

   task automatic load_basic();
      mem[0] = make_word(8'h01, 8'h05);
      mem[1] = make_word(8'h02, 8'h0A);
      mem[2] = make_word(8'h03, 8'h02);
      mem[3] = make_word(8'h0E, 8'h00);
      mem[4] = make_word(8'h0F, 8'h00);
   endtask

   task automatic finish_low(input int n);
      finish = 1'b0;
      repeat (n) @(negedge clock);
   endtask

   // Raises finish at cycle 0 and records the stream for max_cycles cycles.
   task automatic run_stream(input int max_cycles, input int stall_idx, input int stall_len,
                             input int pulse_at);
      int word_idx;
      int stalled;
      logic [15:0] stall_word;
      word_idx = 0;
      stalled = 0;
      stall_word = 16'h0;
      got_data.delete();
      got_cyc.delete();
      rd_count = 0;
      rd_while_valid = 0;
      done_pulses = 0;
      stall_diff = 0;
      out_ready = 1'b1;
      @(negedge clock);
      finish = 1'b1;
      for (int c = 1; c <= max_cycles; c++) begin
         @(negedge clock);
         if (c == pulse_at) finish = 1'b0;
         if (c == pulse_at + 1) finish = 1'b1;
         if (c == 1) begin
            err_c1 = error;
            rden_c1 = rd_en;
            addr_c1 = rd_addr;
         end
         if (rd_en) rd_count++;
         if (rd_en && out_valid) rd_while_valid++;
         if (done) done_pulses++;
         if (out_valid) begin
            if (word_idx == stall_idx && stalled < stall_len) begin
               if (stalled == 0) stall_word = out_data;
               else if (out_data !== stall_word) stall_diff++;
               out_ready = 1'b0;
               stalled++;
            end else begin
               out_ready = 1'b1;
               got_data.push_back(out_data);
               got_cyc.push_back(c);
               word_idx++;
            end
         end else begin
            out_ready = 1'b1;
         end
      end
   endtask

   task automatic test_reset();
      int reads;
      int busy_seen;
      reads = 0;
      busy_seen = 0;
      reset = 1'b0;
      finish = 1'b1;
      repeat (3) @(negedge clock);
      checks++; if (rd_addr !== 13'h0) begin errors++; $display("FAIL reset_rd_addr got %h want 0", rd_addr); end
      checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", rd_en); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
      checks++; if (path_count !== 8'h0) begin errors++; $display("FAIL reset_path_count got %h want 0", path_count); end
      checks++; if ({busy, done, error} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {busy, done, error}); end
      reset = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clock);
         if (rd_en) reads++;
         if (busy) busy_seen++;
      end
      checks++; if (reads !== 0) begin errors++; $display("FAIL reset_held_finish_reads got %0d want 0", reads); end
      checks++; if (busy_seen !== 0) begin errors++; $display("FAIL reset_held_finish_busy got %0d want 0", busy_seen); end
      finish_low(2);
   endtask

   task automatic test_basic();
      logic [15:0] exp_w [5] = '{16'h0105, 16'h020A, 16'h0302, 16'h0E00, 16'h0F00};
      int exp_c [5] = '{3, 6, 9, 12, 15};
      load_basic();
      run_stream(20, -1, 0, -1);
      checks++; if (rden_c1 !== 1'b1 || addr_c1 !== 13'h0) begin errors++; $display("FAIL basic_first_read got en=%b addr=%h want en=1 addr=0", rden_c1, addr_c1); end
      checks++; if (got_data.size() !== 5) begin errors++; $display("FAIL basic_word_count got %0d want 5", got_data.size()); end
      for (int i = 0; i < 5 && i < got_data.size(); i++) begin
         checks++; if (got_data[i] !== exp_w[i] || got_cyc[i] !== exp_c[i]) begin errors++; $display("FAIL basic_word%0d got %h@%0d want %h@%0d", i, got_data[i], got_cyc[i], exp_w[i], exp_c[i]); end
      end
      checks++; if (done_pulses !== 1) begin errors++; $display("FAIL basic_done_pulses got %0d want 1", done_pulses); end
      checks++; if (rd_count !== 5) begin errors++; $display("FAIL basic_reads got %0d want 5", rd_count); end
      checks++; if (path_count !== 8'd1) begin errors++; $display("FAIL basic_path_count got %0d want 1", path_count); end
      checks++; if ({busy, error, out_valid} !== 3'b000) begin errors++; $display("FAIL basic_end_flags got %b want 000", {busy, error, out_valid}); end
      finish_low(2);
   endtask

   task automatic test_stall();
      logic [15:0] exp_w [5] = '{16'h0105, 16'h020A, 16'h0302, 16'h0E00, 16'h0F00};
      int exp_c [5] = '{3, 6, 14, 17, 20};
      run_stream(25, 2, 5, -1);
      checks++; if (got_data.size() !== 5) begin errors++; $display("FAIL stall_word_count got %0d want 5", got_data.size()); end
      for (int i = 0; i < 5 && i < got_data.size(); i++) begin
         checks++; if (got_data[i] !== exp_w[i] || got_cyc[i] !== exp_c[i]) begin errors++; $display("FAIL stall_word%0d got %h@%0d want %h@%0d", i, got_data[i], got_cyc[i], exp_w[i], exp_c[i]); end
      end
      checks++; if (stall_diff !== 0) begin errors++; $display("FAIL stall_data_stable got %0d changes want 0", stall_diff); end
      checks++; if (rd_while_valid !== 0) begin errors++; $display("FAIL stall_reads_during_valid got %0d want 0", rd_while_valid); end
      checks++; if (done_pulses !== 1 || path_count !== 8'd1) begin errors++; $display("FAIL stall_done_count got done=%0d pc=%0d want 1 1", done_pulses, path_count); end
      finish_low(2);
   endtask

   task automatic test_finish_repulse();
      int exp_c [5] = '{3, 6, 9, 12, 15};
      run_stream(20, -1, 0, 7);
      checks++; if (got_data.size() !== 5) begin errors++; $display("FAIL repulse_word_count got %0d want 5", got_data.size()); end
      for (int i = 0; i < 5 && i < got_data.size(); i++) begin
         checks++; if (got_cyc[i] !== exp_c[i]) begin errors++; $display("FAIL repulse_slot%0d got %0d want %0d", i, got_cyc[i], exp_c[i]); end
      end
      checks++; if (got_data.size() == 5 && got_data[4] !== 16'h0F00) begin errors++; $display("FAIL repulse_last got %h want 0F00", got_data[4]); end
      checks++; if (rd_count !== 5 || done_pulses !== 1) begin errors++; $display("FAIL repulse_reads_done got %0d/%0d want 5/1", rd_count, done_pulses); end
      finish_low(2);
   endtask

   task automatic test_illegal_tag();
      mem[1] = make_word(8'h07, 8'hAA);
      run_stream(12, -1, 0, -1);
      checks++; if (got_data.size() !== 1) begin errors++; $display("FAIL illegal_word_count got %0d want 1", got_data.size()); end
      checks++; if (got_data.size() > 0 && got_data[0] !== 16'h0105) begin errors++; $display("FAIL illegal_first_word got %h want 0105", got_data[0]); end
      checks++; if ({error, out_valid, busy, rd_en} !== 4'b1000) begin errors++; $display("FAIL illegal_err_state got %b want 1000", {error, out_valid, busy, rd_en}); end
      checks++; if (rd_count !== 2 || done_pulses !== 0) begin errors++; $display("FAIL illegal_reads_done got %0d/%0d want 2/0", rd_count, done_pulses); end
      finish_low(2);
      checks++; if (error !== 1'b1) begin errors++; $display("FAIL illegal_error_sticky got %b want 1", error); end
      run_stream(12, -1, 0, -1);
      checks++; if (err_c1 !== 1'b0 || rden_c1 !== 1'b1 || addr_c1 !== 13'h0) begin errors++; $display("FAIL illegal_restart got err=%b en=%b addr=%h want 0 1 0", err_c1, rden_c1, addr_c1); end
      checks++; if (got_data.size() !== 1 || error !== 1'b1) begin errors++; $display("FAIL illegal_restart_stream got %0d words err=%b want 1 1", got_data.size(), error); end
      finish_low(2);
      load_basic();
   endtask

   task automatic test_top_address();
      for (int a = 0; a < 8192; a++) mem[a] = make_word(8'h03, a[7:0]);
      run_stream(8192 * 3 + 10, -1, 0, -1);
      checks++; if (got_data.size() !== 8192) begin errors++; $display("FAIL top_word_count got %0d want 8192", got_data.size()); end
      checks++; if (got_data.size() == 8192 && (got_data[100] !== 16'h0364 || got_data[8191] !== 16'h03FF)) begin errors++; $display("FAIL top_words got %h %h want 0364 03FF", got_data[100], got_data[8191]); end
      checks++; if (rd_count !== 8192) begin errors++; $display("FAIL top_reads got %0d want 8192", rd_count); end
      checks++; if (error !== 1'b1 || rd_addr !== 13'h1FFF) begin errors++; $display("FAIL top_no_wrap got err=%b addr=%h want 1 1FFF", error, rd_addr); end
      finish_low(2);
      for (int a = 0; a < 8192; a++) mem[a] = 128'h0;
      load_basic();
   endtask

   task automatic test_reset_midstream();
      int reads;
      reads = 0;
      out_ready = 1'b1;
      @(negedge clock);
      finish = 1'b1;
      repeat (9) @(negedge clock);
      checks++; if (out_valid !== 1'b1 || out_data !== 16'h0302) begin errors++; $display("FAIL midreset_pre got v=%b d=%h want 1 0302", out_valid, out_data); end
      #2 reset = 1'b0;
      #1;
      checks++; if ({rd_addr, rd_en, out_valid, out_data, path_count, busy, done, error} !== 41'h0) begin errors++; $display("FAIL midreset_outputs got addr=%h en=%b v=%b d=%h pc=%h b=%b dn=%b e=%b want all 0", rd_addr, rd_en, out_valid, out_data, path_count, busy, done, error); end
      repeat (2) @(negedge clock);
      reset = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clock);
         if (rd_en) reads++;
      end
      checks++; if (reads !== 0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_no_restart got reads=%0d busy=%b want 0 0", reads, busy); end
      finish_low(2);
      run_stream(20, -1, 0, -1);
      checks++; if (got_data.size() !== 5 || path_count !== 8'd1) begin errors++; $display("FAIL midreset_recover got %0d words pc=%0d want 5 1", got_data.size(), path_count); end
      finish_low(2);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      clock = 1'b0;
      reset = 1'b0;
      finish = 1'b1;
      out_ready = 1'b1;
      for (int a = 0; a < 8192; a++) mem[a] = 128'h0;
      load_basic();
      test_reset();
      test_basic();
      test_stall();
      test_finish_repulse();
      test_illegal_tag();
      test_top_address();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
